// File: rtl/dcache_set_assoc_pkg.sv
// ---------------------------------------------------------------------------
// dcache_set_assoc_pkg : shared request/size encodings and cache FSM states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dcache_set_assoc_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memory_operation_size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } dcache_state_e;

endpackage

`default_nettype wire

// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller : cache FSM, line word counter and L2 word handshake
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_controller
  import dcache_set_assoc_pkg::*;
#(
  parameter int WORDS_PER_LINE = 8,
  parameter int WIDX_BITS      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_req_valid,
  input  logic                 hit,
  input  logic                 victim_dirty,
  input  logic                 l2_word_valid,
  output dcache_state_e        state,
  output logic [WIDX_BITS-1:0] word_idx,
  output logic                 l2_access
);

  localparam logic [WIDX_BITS-1:0] LAST_WORD = WIDX_BITS'(WORDS_PER_LINE - 1);

  // l2_access low for one cycle between words gives the datapath time to
  // move to the next word address before it is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      word_idx  <= '0;
      l2_access <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pipe_req_valid) state <= COMPARE;
        end
        COMPARE: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            word_idx <= '0;
            state    <= victim_dirty ? WRITEBACK : FILL;
          end
        end
        WRITEBACK, FILL: begin
          if (!l2_access) begin
            l2_access <= 1'b1;
          end else if (l2_word_valid) begin
            l2_access <= 1'b0;
            if (word_idx == LAST_WORD) begin
              word_idx <= '0;
              state    <= (state == WRITEBACK) ? FILL : COMPARE;
            end else begin
              word_idx <= word_idx + WIDX_BITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_set_assoc.sv
// ---------------------------------------------------------------------------
// dcache_set_assoc : N-way set-associative write-back/write-allocate L1 dcache
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_set_assoc
  import dcache_set_assoc_pkg::*;
#(
  parameter int LINE_SIZE  = 32,
  parameter int CACHE_SIZE = 1024,
  parameter int XLEN       = 32,
  parameter int NUM_WAYS   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [XLEN-1:0]        pipe_req_address,
  input  memory_operation_size_e pipe_req_size,
  input  memory_operation_e      pipe_req_type,
  input  logic                   pipe_req_valid,
  input  logic [XLEN-1:0]        pipe_req_store_word,
  output logic [XLEN-1:0]        pipe_word,
  output logic                   pipe_word_valid,
  output logic [XLEN-1:0]        l2_address,
  output logic                   l2_access,
  output memory_operation_e      l2_op,
  output logic [XLEN-1:0]        l2_store_word,
  input  logic [XLEN-1:0]        l2_word,
  input  logic                   l2_word_valid
);

  localparam int NUM_SETS       = CACHE_SIZE / (LINE_SIZE * NUM_WAYS);
  localparam int OFS_SIZE       = $clog2(LINE_SIZE);
  localparam int SET_SIZE       = $clog2(NUM_SETS);
  localparam int SET_POS        = OFS_SIZE;
  localparam int TAG_POS        = OFS_SIZE + SET_SIZE;
  localparam int TAG_SIZE       = XLEN - TAG_POS;
  localparam int WORDS_PER_LINE = LINE_SIZE / (XLEN / 8);
  localparam int WIDX_BITS      = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int BYTE_BITS      = $clog2(XLEN / 8);
  localparam int WAY_BITS       = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic [XLEN-1:0]     data_array     [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];
  logic [TAG_SIZE-1:0] tag_array      [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_bits     [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_bits     [NUM_SETS];
  logic [WAY_BITS-1:0] victim_counter [NUM_SETS];

  logic [XLEN-1:0]        req_address;
  memory_operation_size_e req_size;
  memory_operation_e      req_type;
  logic [XLEN-1:0]        req_store_word;
  logic [WAY_BITS-1:0]    victim_way;

  dcache_state_e          state;
  logic [WIDX_BITS-1:0]   word_idx;
  logic                   hit;
  logic [WAY_BITS-1:0]    hit_way;
  logic                   any_invalid;
  logic [WAY_BITS-1:0]    victim_sel;
  logic                   victim_dirty;
  logic [XLEN-1:0]        aligned_address;
  logic [XLEN-1:0]        hit_word;
  logic [XLEN-1:0]        shifted_word;
  logic [XLEN-1:0]        load_word;
  logic [XLEN-1:0]        lane_mask;
  logic [XLEN-1:0]        store_mask;
  logic [XLEN-1:0]        merged_word;
  logic                   l2_done;
  logic                   last_word;

  logic [SET_SIZE-1:0]    req_set;
  logic [TAG_SIZE-1:0]    req_tag;
  logic [WIDX_BITS-1:0]   req_word;
  logic [BYTE_BITS+2:0]   lane_shift;
  logic [XLEN-1:0]        word_offset;
  logic [XLEN-1:0]        victim_base;
  logic [XLEN-1:0]        fill_base;

  assign req_set    = SET_SIZE'(req_address >> SET_POS);
  assign req_tag    = TAG_SIZE'(req_address >> TAG_POS);
  assign req_word   = (WORDS_PER_LINE > 1) ? WIDX_BITS'(req_address >> BYTE_BITS) : '0;
  assign lane_shift = {req_address[BYTE_BITS-1:0], 3'b000};
  assign l2_done    = l2_access && l2_word_valid;
  assign last_word  = (word_idx == WIDX_BITS'(WORDS_PER_LINE - 1));

  always_comb begin
    case (pipe_req_size)
      HALF:    aligned_address = pipe_req_address & ~XLEN'(1);
      WORD:    aligned_address = pipe_req_address & ~XLEN'(3);
      default: aligned_address = pipe_req_address;
    endcase
  end

  // Lowest-index match wins; only one way can match in a consistent cache.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_bits[req_set][w] && (tag_array[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  always_comb begin
    any_invalid = 1'b0;
    victim_sel  = victim_counter[req_set];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_bits[req_set][w]) begin
        any_invalid = 1'b1;
        victim_sel  = WAY_BITS'(w);
      end
    end
    victim_dirty = valid_bits[req_set][victim_sel] && dirty_bits[req_set][victim_sel];
  end

  always_comb begin
    hit_word     = data_array[req_set][hit_way][req_word];
    shifted_word = hit_word >> lane_shift;
    case (req_size)
      BYTE: begin
        load_word = XLEN'(shifted_word[7:0]);
        lane_mask = XLEN'(8'hFF);
      end
      HALF: begin
        load_word = XLEN'(shifted_word[15:0]);
        lane_mask = XLEN'(16'hFFFF);
      end
      default: begin
        load_word = shifted_word;
        lane_mask = '1;
      end
    endcase
    store_mask  = lane_mask << lane_shift;
    merged_word = (hit_word & ~store_mask) | ((req_store_word << lane_shift) & store_mask);
  end

  dcache_controller #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .WIDX_BITS      (WIDX_BITS)
  ) u_controller (
    .clk            (clk),
    .reset          (reset),
    .pipe_req_valid (pipe_req_valid),
    .hit            (hit),
    .victim_dirty   (victim_dirty),
    .l2_word_valid  (l2_word_valid),
    .state          (state),
    .word_idx       (word_idx),
    .l2_access      (l2_access)
  );

  assign pipe_word_valid = (state == COMPARE) && hit;
  assign pipe_word       = (pipe_word_valid && (req_type == LOAD)) ? load_word : '0;
  assign l2_op           = (state == WRITEBACK) ? STORE : LOAD;

  assign word_offset = XLEN'(word_idx) << BYTE_BITS;
  assign victim_base = XLEN'({tag_array[req_set][victim_way], req_set}) << OFS_SIZE;
  assign fill_base   = XLEN'({req_tag, req_set}) << OFS_SIZE;

  always_comb begin
    case (state)
      WRITEBACK: l2_address = victim_base | word_offset;
      FILL:      l2_address = fill_base | word_offset;
      default:   l2_address = '0;
    endcase
    l2_store_word = (state == WRITEBACK) ? data_array[req_set][victim_way][word_idx] : '0;
  end

  // The victim is invalidated as soon as it is chosen so an interrupted
  // writeback or fill can never leave a half-written line marked valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_bits[s]     <= '0;
        dirty_bits[s]     <= '0;
        victim_counter[s] <= '0;
      end
      req_address    <= '0;
      req_size       <= BYTE;
      req_type       <= LOAD;
      req_store_word <= '0;
      victim_way     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pipe_req_valid) begin
            req_address    <= aligned_address;
            req_size       <= pipe_req_size;
            req_type       <= pipe_req_type;
            req_store_word <= pipe_req_store_word;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (req_type == STORE) dirty_bits[req_set][hit_way] <= 1'b1;
          end else begin
            victim_way                       <= victim_sel;
            valid_bits[req_set][victim_sel] <= 1'b0;
            if ((NUM_WAYS > 1) && !any_invalid)
              victim_counter[req_set] <= victim_counter[req_set] + WAY_BITS'(1);
          end
        end
        WRITEBACK: begin
          if (l2_done && last_word) dirty_bits[req_set][victim_way] <= 1'b0;
        end
        FILL: begin
          if (l2_done && last_word) begin
            valid_bits[req_set][victim_way] <= 1'b1;
            dirty_bits[req_set][victim_way] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((state == COMPARE) && hit && (req_type == STORE))
        data_array[req_set][hit_way][req_word] <= merged_word;
      if ((state == FILL) && l2_done) begin
        data_array[req_set][victim_way][word_idx] <= l2_word;
        if (last_word) tag_array[req_set][victim_way] <= req_tag;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_set_assoc.sv
// ---------------------------------------------------------------------------
// tb_dcache_set_assoc : directed vector bench with an L2 word-serial model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dcache_set_assoc;
  import dcache_set_assoc_pkg::*;

  logic                   clk;
  logic                   reset;
  logic [31:0]            pipe_req_address;
  memory_operation_size_e pipe_req_size;
  memory_operation_e      pipe_req_type;
  logic                   pipe_req_valid;
  logic [31:0]            pipe_req_store_word;
  logic [31:0]            pipe_word;
  logic                   pipe_word_valid;
  logic [31:0]            l2_address;
  logic                   l2_access;
  memory_operation_e      l2_op;
  logic [31:0]            l2_store_word;
  logic [31:0]            l2_word;
  logic                   l2_word_valid;

  dcache_set_assoc dut (
    .clk                 (clk),
    .reset               (reset),
    .pipe_req_address    (pipe_req_address),
    .pipe_req_size       (pipe_req_size),
    .pipe_req_type       (pipe_req_type),
    .pipe_req_valid      (pipe_req_valid),
    .pipe_req_store_word (pipe_req_store_word),
    .pipe_word           (pipe_word),
    .pipe_word_valid     (pipe_word_valid),
    .l2_address          (l2_address),
    .l2_access           (l2_access),
    .l2_op               (l2_op),
    .l2_store_word       (l2_store_word),
    .l2_word             (l2_word),
    .l2_word_valid       (l2_word_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    memory_operation_e op;
    logic [31:0]       addr;
    logic [31:0]       data;
  } l2_txn_t;

  typedef struct {
    logic [31:0]            addr;
    memory_operation_size_e size;
    memory_operation_e      op;
    logic [31:0]            sdata;
    logic [31:0]            exp_word;
    int                     n_wb;
    logic [31:0]            wb_base;
    logic [31:0]            wb1_data;
    int                     n_fill;
    logic [31:0]            fill_base;
  } vec_t;

  l2_txn_t     log_q[$];
  logic [31:0] l2_mem [logic [31:0]];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          pwv_count = 0;
  vec_t        vecs [18];

  // Untouched L2 words read back as C0DE_<low address half>.
  function automatic logic [31:0] l2_read(input logic [31:0] a);
    if (l2_mem.exists(a)) return l2_mem[a];
    return 32'hC0DE0000 | {16'h0000, a[15:0]};
  endfunction

  initial begin
    l2_txn_t t;
    l2_word       = '0;
    l2_word_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (l2_word_valid) begin
        l2_word_valid = 1'b0;
      end else if (l2_access) begin
        t.op   = l2_op;
        t.addr = l2_address;
        t.data = l2_store_word;
        log_q.push_back(t);
        if (l2_op == STORE) l2_mem[l2_address] = l2_store_word;
        else l2_word = l2_read(l2_address);
        l2_word_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) if (pipe_word_valid) pwv_count++;

  always @(posedge clk)
    assert (reset || !l2_access || pipe_req_valid)
      else $error("FAIL assert_req_held: pipe_req_valid dropped during miss");

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    logic [31:0] rd;
    int          cyc;
    bit          done;
    bit          order_ok;
    int          n_exp;
    @(negedge clk);
    log_q.delete();
    pipe_req_address    = v.addr;
    pipe_req_size       = v.size;
    pipe_req_type       = v.op;
    pipe_req_store_word = v.sdata;
    pipe_req_valid      = 1'b1;
    cyc  = 0;
    done = 1'b0;
    rd   = '0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (pipe_word_valid) begin
        done = 1'b1;
        rd   = pipe_word;
      end
    end
    pipe_req_valid = 1'b0;
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " pipe_word"}, rd, v.exp_word);
    n_exp = v.n_wb + v.n_fill;
    check({tag, " l2 count"}, 32'(log_q.size()), 32'(n_exp));
    order_ok = (log_q.size() == n_exp);
    for (int k = 0; k < log_q.size() && k < n_exp; k++) begin
      if (k < v.n_wb) begin
        if (log_q[k].op != STORE || log_q[k].addr != v.wb_base + 32'(4 * k)) order_ok = 1'b0;
      end else begin
        if (log_q[k].op != LOAD || log_q[k].addr != v.fill_base + 32'(4 * (k - v.n_wb))) order_ok = 1'b0;
      end
    end
    if (n_exp > 0) check({tag, " l2 sequence"}, 32'(order_ok), 32'd1);
    if (v.n_wb > 1 && log_q.size() > 1) check({tag, " wb word1 data"}, log_q[1].data, v.wb1_data);
    if (n_exp == 0) check({tag, " hit latency"}, 32'(cyc), 32'd1);
  endtask

  initial begin
    bit   found;
    int   pwv_before;
    vec_t v;

    vecs[0]  = '{32'h040, WORD, LOAD,  32'h0,        32'hC0DE0040, 0, 32'h0,   32'h0,        8, 32'h040};
    vecs[1]  = '{32'h044, WORD, LOAD,  32'h0,        32'hC0DE0044, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[2]  = '{32'h041, BYTE, STORE, 32'h000000AB, 32'h0,        0, 32'h0,   32'h0,        0, 32'h0};
    vecs[3]  = '{32'h040, WORD, LOAD,  32'h0,        32'hC0DEAB40, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[4]  = '{32'h041, BYTE, LOAD,  32'h0,        32'h000000AB, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[5]  = '{32'h047, HALF, LOAD,  32'h0,        32'h0000C0DE, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[6]  = '{32'h05F, BYTE, LOAD,  32'h0,        32'h000000C0, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[7]  = '{32'h000, WORD, LOAD,  32'h0,        32'hC0DE0000, 0, 32'h0,   32'h0,        8, 32'h000};
    vecs[8]  = '{32'h200, WORD, LOAD,  32'h0,        32'hC0DE0200, 0, 32'h0,   32'h0,        8, 32'h200};
    vecs[9]  = '{32'h004, WORD, STORE, 32'h12345678, 32'h0,        0, 32'h0,   32'h0,        0, 32'h0};
    vecs[10] = '{32'h400, WORD, LOAD,  32'h0,        32'hC0DE0400, 8, 32'h000, 32'h12345678, 8, 32'h400};
    vecs[11] = '{32'h600, WORD, LOAD,  32'h0,        32'hC0DE0600, 0, 32'h0,   32'h0,        8, 32'h600};
    vecs[12] = '{32'h004, WORD, LOAD,  32'h0,        32'h12345678, 0, 32'h0,   32'h0,        8, 32'h000};
    vecs[13] = '{32'h802, HALF, STORE, 32'h0000BEEF, 32'h0,        0, 32'h0,   32'h0,        8, 32'h800};
    vecs[14] = '{32'h800, WORD, LOAD,  32'h0,        32'hBEEF0800, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[15] = '{32'h801, HALF, LOAD,  32'h0,        32'h00000800, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[16] = '{32'h043, BYTE, STORE, 32'h000001FF, 32'h0,        0, 32'h0,   32'h0,        0, 32'h0};
    vecs[17] = '{32'h040, WORD, LOAD,  32'h0,        32'hFFDEAB40, 0, 32'h0,   32'h0,        0, 32'h0};

    reset               = 1'b1;
    pipe_req_address    = '0;
    pipe_req_size       = BYTE;
    pipe_req_type       = LOAD;
    pipe_req_valid      = 1'b0;
    pipe_req_store_word = '0;
    repeat (3) @(negedge clk);
    check("reset pipe_word_valid", 32'(pipe_word_valid), 32'd0);
    check("reset pipe_word", pipe_word, 32'd0);
    check("reset l2_access", 32'(l2_access), 32'd0);
    check("reset l2_address", l2_address, 32'd0);
    check("reset l2_store_word", l2_store_word, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Dirty set 0 way 0, then miss on it and reset in the middle of writeback.
    v = '{32'h000, WORD, STORE, 32'hCAFEF00D, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0};
    apply_vec(v, "rst_prep_store");
    @(negedge clk);
    pipe_req_address = 32'hA00;
    pipe_req_size    = WORD;
    pipe_req_type    = LOAD;
    pipe_req_valid   = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (l2_access && l2_op == STORE && l2_address == 32'h00C) found = 1'b1;
    end
    check("rst reached wb word3", 32'(found), 32'd1);
    reset          = 1'b1;
    pipe_req_valid = 1'b0;
    pwv_before     = pwv_count;
    @(negedge clk);
    check("rst l2_access dropped", 32'(l2_access), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst no pipe_word_valid", 32'(pwv_count), 32'(pwv_before));
    check("rst idle l2_access", 32'(l2_access), 32'd0);

    v = '{32'h000, WORD, LOAD, 32'h0, 32'hCAFEF00D, 0, 32'h0, 32'h0, 8, 32'h000};
    apply_vec(v, "rst_refill");
    v = '{32'h004, WORD, LOAD, 32'h0, 32'h12345678, 0, 32'h0, 32'h0, 0, 32'h0};
    apply_vec(v, "rst_hit_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_set_assoc.md
Name: dcache_set_assoc

Overview:
- Parametrised N-way set-associative, write-back, write-allocate L1 data cache; next generation of the direct-mapped read-only dcache.
- Sits between the pipeline memory stage and L2.
- Adds stores (byte/half/word), dirty-line writeback and a per-set victim policy.
- L2 transfers are word-serial: one word per L2 handshake.

Parameters:
- LINE_SIZE, 32, bytes per line (power of two, at least XLEN/8).
- CACHE_SIZE, 1024, total data bytes (power of two).
- XLEN, 32, address/word width in bits.
- NUM_WAYS, 2, associativity (power of two, at least 1). NUM_SETS = CACHE_SIZE/(LINE_SIZE*NUM_WAYS) must be at least 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pipe_req_address  in  XLEN  byte address of request.
- pipe_req_size  in  memory_operation_size_e  BYTE/HALF/WORD.
- pipe_req_type  in  memory_operation_e  LOAD/STORE.
- pipe_req_valid  in  1  request present; held stable until pipe_word_valid.
- pipe_req_store_word  in  XLEN  store data, right-justified.
- pipe_word  out  XLEN  load data, right-justified, zero-extended; 0 for stores.
- pipe_word_valid  out  1  one-cycle completion pulse (loads and stores).
- l2_address  out  XLEN  word-aligned L2 address.
- l2_access  out  1  L2 request; held until l2_word_valid.
- l2_op  out  memory_operation_e  LOAD = fill read, STORE = writeback.
- l2_store_word  out  XLEN  writeback data.
- l2_word  in  XLEN  fill data, valid with l2_word_valid.
- l2_word_valid  in  1  one-cycle completion of the current L2 access.

Behaviour:
- Reset (synchronous, active-high): all valid/dirty bits and victim counters cleared; FSM goes to IDLE. All outputs are 0 at reset and while in IDLE.
- Address split: ofs = low log2(LINE_SIZE) bits, set = next log2(NUM_SETS), tag = remainder.
- Alignment: the low address bits below the access size are ignored (HALF clears bit0, WORD clears bits 1:0).
- FSM states: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE: if pipe_req_valid, register the request and go to COMPARE.
- COMPARE on hit:
  - LOAD: pipe_word = selected lane, zero-extended.
  - STORE: merge the size-selected bytes into the line and set dirty.
  - Assert pipe_word_valid for one cycle and return to IDLE.
  - Hit latency is exactly 1 cycle after acceptance. The next request may be accepted the cycle after pipe_word_valid.
- COMPARE on miss, victim selection:
  - Choose the lowest-index invalid way; the victim counter is unchanged.
  - If no way is invalid, the victim is way[counter] and that set's counter increments modulo NUM_WAYS.
  - Victim dirty: go to WRITEBACK. Otherwise go to FILL.
- WRITEBACK: for w = 0..WORDS_PER_LINE-1:
  - l2_op=STORE, l2_address = {victim_tag,set,w*XLEN/8}, l2_store_word = victim word w.
  - Advance w on l2_word_valid.
  - After the last word, clear dirty and go to FILL.
- FILL: for w = 0..WORDS_PER_LINE-1:
  - l2_op=LOAD, address = {req_tag,set,w*XLEN/8}.
  - On l2_word_valid, write l2_word into the victim word w.
  - After the last word, set tag and valid, clear dirty, and return to COMPARE. The access then hits and completes as above.
- l2_access:
  - Deasserts for exactly one cycle between consecutive words; address and data are updated in that gap.
  - Never asserted outside WRITEBACK/FILL.
- l2_word_valid in IDLE or COMPARE is ignored.
- Reset mid-operation: l2_access drops the cycle after reset is sampled. The in-flight request is discarded with no pipe_word_valid. Dirty data is lost.
- pipe_req_valid dropping during a miss is illegal (checked by bench assertion; not handled).
- Storage is register arrays: data[NUM_SETS][NUM_WAYS][LINE_SIZE*8], tag, valid, dirty, and per-set counter[log2(NUM_WAYS)] (0-width when NUM_WAYS=1; the victim is then always way 0).

Decomposition:
- Shared package: memory_operation_e, memory_operation_size_e, and a new dcache_state_e {IDLE, COMPARE, WRITEBACK, FILL}.
- Per-instance derived localparams (NUM_SETS, OFS/SET/TAG_SIZE/POS, WORDS_PER_LINE) stay in the module.
- Sub-module dcache_controller holds the FSM, word counter, and L2 handshake.
- Top level holds arrays, tag compare, byte-lane merge and the victim select.

Test Plan (defaults: 16 sets, set stride 0x200, 8 words/line):
- Cold LOAD WORD 0x040 -> 8 L2 LOADs at 0x040..0x05C, then pipe_word = L2 data of 0x040. LOAD 0x044 then hits: pipe_word_valid 1 cycle after accept, no l2_access.
- After the fill, STORE BYTE 0xAB to 0x041, then LOAD WORD 0x040 -> bits 15:8 = 0xAB, other bytes unchanged, no L2 traffic.
- Fill 0x000 and 0x200, STORE to 0x000, then LOAD 0x400 -> way0 evicted: 8 L2 STOREs 0x000..0x01C carrying the stored data, then 8 LOADs 0x400..0x41C.
- Then LOAD 0x600 -> victim way1 (0x200, clean): no L2 STOREs, only LOADs 0x600..0x61C. Counter wraps to 0.
- STORE HALF 0xBEEF to 0x802 on a miss -> fill 0x800..0x81C, then merge. Subsequent LOAD WORD 0x800 bits 31:16 = 0xBEEF.
- Assert reset during WRITEBACK word 3 -> l2_access 0 next cycle, no pipe_word_valid. A subsequent LOAD 0x000 misses with a clean fill.
